// File: rtl/div_seq_if.sv
// Start/ready handshake and operand/result bundle for the sequential divider.
interface div_seq_if #(parameter int unsigned DW = 8);
  logic          i_start;
  logic [DW-1:0] i_dividend;
  logic [DW-1:0] i_divisor;
  logic [DW-1:0] o_quotient;
  logic [DW-1:0] o_remainder;
  logic          o_busy;
  logic          o_ready;
  logic          o_dz;
  logic          o_ovf;

  modport master (
    output i_start, i_dividend, i_divisor,
    input  o_quotient, o_remainder, o_busy, o_ready, o_dz, o_ovf
  );

  modport slave (
    input  i_start, i_dividend, i_divisor,
    output o_quotient, o_remainder, o_busy, o_ready, o_dz, o_ovf
  );
endinterface

// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per clock, start/ready handshake.
// Define DIV_SEQ_SIGNED_EN for two's-complement operands via sign-magnitude conversion.
module div_seq #(
  parameter int unsigned DW = 8
) (
  input  logic      i_clk,
  input  logic      i_rst,
  div_seq_if.slave  bus
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [DW-1:0] dd_q;
  logic [DW-1:0] dv_q;
  logic [DW-1:0] quo_q;
  logic [DW-1:0] rem_q;
  logic [DW-1:0] dvs_q;
  logic [CW-1:0] cnt_q;
  logic          dz_pend_q;
`ifdef DIV_SEQ_SIGNED_EN
  logic          sign_q_q;
  logic          sign_r_q;
  logic          ovf_pend_q;
`endif

  logic [DW-1:0] quotient_q;
  logic [DW-1:0] remainder_q;
  logic          busy_q;
  logic          ready_q;
  logic          dz_q;
  logic          ovf_q;

  // One restoring step: shift next dividend bit into the partial remainder and trial-subtract.
  logic [DW:0] r_sh;
  logic [DW:0] r_sub;
  always_comb begin
    r_sh  = {rem_q, quo_q[DW-1]};
    r_sub = r_sh - {1'b0, dvs_q};
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= S_IDLE;
      dd_q        <= '0;
      dv_q        <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      dz_pend_q   <= 1'b0;
`ifdef DIV_SEQ_SIGNED_EN
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      ovf_pend_q  <= 1'b0;
`endif
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.i_start) begin
            dd_q    <= bus.i_dividend;
            dv_q    <= bus.i_divisor;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= S_LOAD;
          end
        end

        S_LOAD: begin
`ifdef DIV_SEQ_SIGNED_EN
          quo_q      <= dd_q[DW-1] ? -dd_q : dd_q;
          dvs_q      <= dv_q[DW-1] ? -dv_q : dv_q;
          sign_q_q   <= dd_q[DW-1] ^ dv_q[DW-1];
          sign_r_q   <= dd_q[DW-1];
          ovf_pend_q <= (dd_q == {1'b1, {(DW-1){1'b0}}}) && (dv_q == '1);
`else
          quo_q      <= dd_q;
          dvs_q      <= dv_q;
`endif
          rem_q     <= '0;
          cnt_q     <= CW'(DW - 1);
          dz_pend_q <= (dv_q == '0);
          // Zero divisor skips the iterations but still passes FIX so ready lands two edges after start.
          state_q   <= (dv_q == '0) ? S_FIX : S_ITER;
        end

        S_ITER: begin
          if (r_sh >= {1'b0, dvs_q}) begin
            rem_q <= DW'(r_sub);
            quo_q <= {quo_q[DW-2:0], 1'b1};
          end else begin
            rem_q <= DW'(r_sh);
            quo_q <= {quo_q[DW-2:0], 1'b0};
          end
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) state_q <= S_FIX;
        end

        S_FIX: begin
          if (dz_pend_q) begin
            quotient_q  <= '1;
            remainder_q <= dd_q;
          end else begin
`ifdef DIV_SEQ_SIGNED_EN
            quotient_q  <= sign_q_q ? -quo_q : quo_q;
            remainder_q <= sign_r_q ? -rem_q : rem_q;
            ovf_q       <= ovf_pend_q;
`else
            quotient_q  <= quo_q;
            remainder_q <= rem_q;
`endif
          end
          dz_q    <= dz_pend_q;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_DONE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_quotient  = quotient_q;
  assign bus.o_remainder = remainder_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_ready     = ready_q;
  assign bus.o_dz        = dz_q;
  assign bus.o_ovf       = ovf_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed and random divisions against an arithmetic model.
module tb_div_seq;

  localparam int unsigned DW = 8;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic [DW-1:0] prev_q;
  logic [DW-1:0] prev_r;

  div_seq_if #(.DW(DW)) bus ();

  div_seq #(.DW(DW)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Truncating division from plain integer arithmetic.
  function automatic void model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                output logic [DW-1:0] q, output logic [DW-1:0] r,
                                output logic dz, output logic ovf);
    int sa;
    int sb;
    dz  = 1'b0;
    ovf = 1'b0;
    if (b == '0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else begin
`ifdef DIV_SEQ_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -(1 << (DW-1)) && sb == -1) begin
        q   = DW'(1 << (DW-1));
        r   = '0;
        ovf = 1'b1;
      end else begin
        q = DW'(sa / sb);
        r = DW'(sa % sb);
      end
`else
      sa = int'(a);
      sb = int'(b);
      q  = DW'(sa / sb);
      r  = DW'(sa % sb);
`endif
    end
  endfunction

  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit noise);
    logic [DW-1:0] eq;
    logic [DW-1:0] er;
    logic edz;
    logic eovf;
    int lat;
    int exp_lat;
    bit seen;
    model(a, b, eq, er, edz, eovf);
    exp_lat = edz ? 2 : int'(DW) + 2;
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_dividend = a;
    bus.i_divisor  = b;
    @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b0;
    chk("busy_after_start", 32'(bus.o_busy), 32'd1);
    chk("ready_after_start", 32'(bus.o_ready), 32'd0);
    chk("q_held_busy", 32'(bus.o_quotient), 32'(prev_q));
    chk("r_held_busy", 32'(bus.o_remainder), 32'(prev_r));
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen = bus.o_ready;
      bus.i_start = noise && !seen && (lat % 3 == 1);
      if (bus.i_start) begin
        bus.i_dividend = DW'($urandom);
        bus.i_divisor  = DW'($urandom);
      end
    end
    bus.i_start = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("quotient", 32'(bus.o_quotient), 32'(eq));
    chk("remainder", 32'(bus.o_remainder), 32'(er));
    chk("dz", 32'(bus.o_dz), 32'(edz));
    chk("ovf", 32'(bus.o_ovf), 32'(eovf));
    chk("busy_done", 32'(bus.o_busy), 32'd0);
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] eq;
    logic [DW-1:0] er;
    logic edz;
    logic eovf;
    int lat;
    bit seen;
    vectors     = 0;
    miscompares = 0;
    prev_q      = '0;
    prev_r      = '0;
    rst_n          = 1'b0;
    bus.i_start    = 1'b0;
    bus.i_dividend = '0;
    bus.i_divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_q", 32'(bus.o_quotient), 32'd0);
    chk("rst_r", 32'(bus.o_remainder), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_ready", 32'(bus.o_ready), 32'd0);
    rst_n = 1'b1;

    // Directed cases, including zero divisor and the signed overflow corner.
`ifdef DIV_SEQ_SIGNED_EN
    run_op(8'd100, 8'd7,   1'b0);
    run_op(8'h9C,  8'd7,   1'b0);
    run_op(8'd100, 8'hF9,  1'b0);
    run_op(8'd5,   8'd0,   1'b0);
    run_op(8'h80,  8'hFF,  1'b0);
    run_op(8'h80,  8'h01,  1'b0);
`else
    run_op(8'd200, 8'd7,   1'b0);
    run_op(8'd5,   8'd0,   1'b0);
    run_op(8'd100, 8'd7,   1'b0);
    run_op(8'hFF,  8'hFF,  1'b0);
`endif

    // Reset four iterations into ITER clears everything immediately.
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_dividend = 8'd77;
    bus.i_divisor  = 8'd3;
    @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("busy_pre_reset", 32'(bus.o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q", 32'(bus.o_quotient), 32'd0);
    chk("mid_rst_r", 32'(bus.o_remainder), 32'd0);
    chk("mid_rst_busy", 32'(bus.o_busy), 32'd0);
    chk("mid_rst_ready", 32'(bus.o_ready), 32'd0);
    chk("mid_rst_dz", 32'(bus.o_dz), 32'd0);
    chk("mid_rst_ovf", 32'(bus.o_ovf), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    prev_q = '0;
    prev_r = '0;
    run_op(8'd50, 8'd5, 1'b1);

    // Start held high across DONE restarts back to back.
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_dividend = 8'd91;
    bus.i_divisor  = 8'd4;
    @(posedge clk);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen = bus.o_ready;
    end
    model(8'd91, 8'd4, eq, er, edz, eovf);
    chk("b2b_lat1", 32'(lat), 32'(DW + 2));
    chk("b2b_q1", 32'(bus.o_quotient), 32'(eq));
    bus.i_dividend = 8'd33;
    bus.i_divisor  = 8'd6;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_ready_drop", 32'(bus.o_ready), 32'd0);
    chk("b2b_q_hold", 32'(bus.o_quotient), 32'(eq));
    bus.i_start = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen = bus.o_ready;
    end
    model(8'd33, 8'd6, eq, er, edz, eovf);
    chk("b2b_lat2", 32'(lat), 32'(DW + 2));
    chk("b2b_q2", 32'(bus.o_quotient), 32'(eq));
    chk("b2b_r2", 32'(bus.o_remainder), 32'(er));
    prev_q = eq;
    prev_r = er;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("done_ready_hold", 32'(bus.o_ready), 32'd1);

    // Random operands with occasional zero divisors and overflow corners.
    for (int i = 0; i < 40; i++) begin
      a = DW'($urandom);
      b = DW'($urandom);
      if (i % 8 == 3) b = '0;
      if (i % 10 == 7) begin
        a = {1'b1, {(DW-1){1'b0}}};
        b = '1;
      end
      run_op(a, b, (i % 2) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
